// File: rtl/fp_unit_share_arbiter.sv
// Round-robin arbiter that time-shares one fp unit between N_REQ requesters.
// One operation is in flight at a time, and a watchdog aborts hung operations.
module fp_unit_share_arbiter #(
  parameter int DBL_WIDTH   = 64,
  parameter int N_REQ       = 4,
  parameter int IDX_W       = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DBL_WIDTH-1:0] req_a,
  input  logic [N_REQ*DBL_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]           req_ack,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DBL_WIDTH-1:0]       rsp_data,
  output logic                       unit_valid,
  input  logic                       unit_ready,
  output logic [DBL_WIDTH-1:0]       unit_a,
  output logic [DBL_WIDTH-1:0]       unit_b,
  input  logic                       unit_finish,
  input  logic [DBL_WIDTH-1:0]       unit_result,
  output logic                       busy,
  output logic [IDX_W-1:0]           owner_id,
  output logic                       timeout_err
);

  localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [15:0]      timer;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;

  // Search upward from the requester after the last grant, wrapping once.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ack     <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      unit_valid  <= 1'b0;
      unit_a      <= '0;
      unit_b      <= '0;
      busy        <= 1'b0;
      owner_id    <= '0;
      timeout_err <= 1'b0;
      last_grant  <= LAST_INIT;
      timer       <= '0;
    end else begin
      req_ack    <= '0;
      rsp_valid  <= '0;
      unit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            owner_id <= grant_idx;
            unit_a   <= req_a[int'(grant_idx)*DBL_WIDTH +: DBL_WIDTH];
            unit_b   <= req_b[int'(grant_idx)*DBL_WIDTH +: DBL_WIDTH];
            state    <= ISSUE;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (unit_ready) begin
            unit_valid        <= 1'b1;
            req_ack[owner_id] <= 1'b1;
            timer             <= '0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          // A finish on the watchdog's final cycle still completes normally.
          if (unit_finish) begin
            rsp_data            <= unit_result;
            rsp_valid[owner_id] <= 1'b1;
            last_grant          <= owner_id;
            state               <= IDLE;
            busy                <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            last_grant  <= owner_id;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unit_share_arbiter.sv
// Randomized and directed bench for fp_unit_share_arbiter against a transaction-level
// model of the round-robin / timeout rules, with a behavioural multiplier as the shared unit.
module tb_fp_unit_share_arbiter;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     req_ack, rsp_valid;
  logic [W-1:0]     rsp_data, unit_a, unit_b, unit_result;
  logic             unit_valid, unit_ready, unit_finish, busy, timeout_err;
  logic [IW-1:0]    owner_id;

  always #5 clk = ~clk;

  fp_unit_share_arbiter #(.DBL_WIDTH(W), .N_REQ(N), .IDX_W(IW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_a(unit_a), .unit_b(unit_b),
    .unit_finish(unit_finish), .unit_result(unit_result),
    .busy(busy), .owner_id(owner_id), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: one outstanding operation, grant = first pending after the last owner.
  logic [N-1:0]  exp_ack, exp_rsp;
  logic          exp_valid, exp_busy, exp_err;
  logic [W-1:0]  exp_data, exp_a, exp_b;
  logic [IW-1:0] exp_owner;
  int            m_last, m_idx, m_wait;
  bit            m_granted, m_issued;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_ack = '0; exp_rsp = '0; exp_valid = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
      exp_data = '0; exp_a = '0; exp_b = '0; exp_owner = '0;
      m_last = N - 1; m_granted = 1'b0; m_issued = 1'b0; m_wait = 0;
    end else begin
      exp_ack = '0; exp_rsp = '0; exp_valid = 1'b0;
      if (!m_granted) begin
        for (int k = 1; k <= N; k++) begin
          m_idx = (m_last + k) % N;
          if (!m_granted && req_valid[m_idx[IW-1:0]]) begin
            m_granted = 1'b1; m_issued = 1'b0;
            exp_owner = m_idx[IW-1:0];
            exp_a = req_a[m_idx*W +: W];
            exp_b = req_b[m_idx*W +: W];
            exp_busy = 1'b1;
          end
        end
      end else if (!m_issued) begin
        if (unit_ready) begin
          m_issued = 1'b1; m_wait = 0; exp_valid = 1'b1; exp_ack[exp_owner] = 1'b1;
        end
      end else begin
        m_wait++;
        if (unit_finish) begin
          exp_data = unit_result; exp_rsp[exp_owner] = 1'b1;
          m_last = int'(exp_owner); m_granted = 1'b0; exp_busy = 1'b0;
        end else if (m_wait == TO) begin
          exp_err = 1'b1; m_last = int'(exp_owner); m_granted = 1'b0; exp_busy = 1'b0;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("req_ack", 64'(req_ack), 64'(exp_ack));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      checkOutput("rsp_data", rsp_data, exp_data);
      checkOutput("unit_valid", 64'(unit_valid), 64'(exp_valid));
      checkOutput("unit_a", unit_a, exp_a);
      checkOutput("unit_b", unit_b, exp_b);
      checkOutput("busy", 64'(busy), 64'(exp_busy));
      checkOutput("owner_id", 64'(owner_id), 64'(exp_owner));
      checkOutput("timeout_err", 64'(timeout_err), 64'(exp_err));
    end
  end

  // Behavioural shared multiplier plus requester hold-until-ack behaviour.
  bit          unit_auto = 1'b1;
  bit          spurious_en = 1'b0;
  bit          hold_all = 1'b0;
  int          unit_lat = 4;
  int          pend_cnt = 0;
  logic [63:0] pend_res;
  int          ack_log[$];
  logic [63:0] rsp_log[$];

  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      unit_finish = 1'b0;
      if (unit_auto) begin
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            unit_finish = 1'b1;
            unit_result = pend_res;
          end
        end else if (spurious_en && $urandom_range(0, 19) == 0) begin
          unit_finish = 1'b1;
          unit_result = {32'h0, $urandom()};
        end
        if (unit_valid) begin
          pend_res = $realtobits($bitstoreal(unit_a) * $bitstoreal(unit_b));
          pend_cnt = unit_lat;
        end
      end
      for (int i = 0; i < N; i++) if (req_ack[i]) ack_log.push_back(i);
      if (rsp_valid != '0) rsp_log.push_back(rsp_data);
      if (!hold_all) req_valid = req_valid & ~req_ack;
    end
  endtask

  task automatic waitFor(input int what, input string tag, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 300) begin
      applyStimulus(1);
      cycles++;
      case (what)
        0: seen = (req_ack != '0);
        1: seen = (rsp_valid != '0);
        default: seen = timeout_err;
      endcase
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  task automatic doReset();
    rst_n = 1'b0; req_valid = '0; pend_cnt = 0;
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(1);
  endtask

  int cyc;
  int pulses;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    unit_ready = 1'b1; unit_finish = 1'b0; unit_result = '0;
    applyStimulus(3);
    chk_en = 1'b1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_owner", 64'(owner_id), 64'd0);
    checkOutput("reset_unit_a", unit_a, 64'd0);
    rst_n = 1'b1;
    applyStimulus(2);

    // Single request from requester 2: 3.0 * 2.0
    req_a[2*W +: W] = 64'h4008_0000_0000_0000;
    req_b[2*W +: W] = 64'h4000_0000_0000_0000;
    unit_lat = 6;
    req_valid = 4'b0100;
    waitFor(0, "single_ack_seen", cyc);
    checkOutput("single_ack", 64'(req_ack), 64'h4);
    checkOutput("single_owner", 64'(owner_id), 64'd2);
    waitFor(1, "single_rsp_seen", cyc);
    checkOutput("single_rsp", 64'(rsp_valid), 64'h4);
    checkOutput("single_data", rsp_data, 64'h4018_0000_0000_0000);
    applyStimulus(1);
    checkOutput("single_rsp_pulse", 64'(rsp_valid), 64'h0);

    // All four held continuously: grants rotate 0,1,2,3,0
    doReset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $realtobits(real'(i));
      req_b[i*W +: W] = 64'h3FF0_0000_0000_0000;
    end
    ack_log.delete(); rsp_log.delete();
    unit_lat = 3; hold_all = 1'b1; req_valid = 4'hF;
    for (int g = 0; g < 5; g++) waitFor(1, "rr_rsp_seen", cyc);
    hold_all = 1'b0; req_valid = '0;
    applyStimulus(3);
    for (int g = 0; g < 5; g++) begin
      checkOutput("rr_order", 64'(ack_log.size() > g ? ack_log[g] : -1), 64'(g % N));
      checkOutput("rr_data", rsp_log.size() > g ? rsp_log[g] : 64'hX, $realtobits(real'(g % N)));
    end

    // Backpressure: ready low for 10 cycles, operand change during the stall is ignored
    unit_ready = 1'b0; unit_lat = 2;
    req_a[1*W +: W] = 64'h4022_0000_0000_0000;
    req_b[1*W +: W] = 64'h3FF0_0000_0000_0000;
    req_valid = 4'b0010;
    applyStimulus(1);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1);
      if (unit_valid || req_ack != '0) pulses++;
      if (c == 3) req_a[1*W +: W] = 64'hC000_0000_0000_0000;
    end
    checkOutput("bp_stall_pulses", 64'(pulses), 64'd0);
    unit_ready = 1'b1;
    applyStimulus(1);
    checkOutput("bp_unit_valid", 64'(unit_valid), 64'd1);
    checkOutput("bp_ack", 64'(req_ack), 64'h2);
    checkOutput("bp_unit_a", unit_a, 64'h4022_0000_0000_0000);
    applyStimulus(1);
    checkOutput("bp_valid_pulse", 64'(unit_valid), 64'd0);
    waitFor(1, "bp_rsp_seen", cyc);
    checkOutput("bp_data", rsp_data, 64'h4022_0000_0000_0000);

    // Timeout: unit never finishes, next pending requester gets granted
    unit_lat = 0;
    req_valid = 4'b1000;
    waitFor(0, "to_ack_seen", cyc);
    req_valid[0] = 1'b1;
    waitFor(2, "to_err_seen", cyc);
    checkOutput("to_cycles", 64'(cyc), 64'd16);
    unit_ready = 1'b0;
    applyStimulus(1);
    checkOutput("to_next_owner", 64'(owner_id), 64'd0);
    unit_auto = 1'b0;
    unit_finish = 1'b1; unit_result = 64'h1234;
    applyStimulus(1);
    checkOutput("to_late_finish", 64'(rsp_valid), 64'd0);
    unit_auto = 1'b1; unit_lat = 3; unit_ready = 1'b1;
    waitFor(1, "to_next_rsp_seen", cyc);
    checkOutput("to_next_rsp", 64'(rsp_valid), 64'h1);
    checkOutput("to_sticky", 64'(timeout_err), 64'd1);

    // Finish on the same edge as the watchdog limit: finish wins
    doReset();
    unit_lat = 0;
    req_valid = 4'b0100;
    waitFor(0, "same_ack_seen", cyc);
    applyStimulus(TO - 1);
    unit_auto = 1'b0;
    unit_finish = 1'b1; unit_result = 64'h4014_0000_0000_0000;
    applyStimulus(1);
    unit_auto = 1'b1;
    checkOutput("same_rsp", 64'(rsp_valid), 64'h4);
    checkOutput("same_err", 64'(timeout_err), 64'd0);

    // Reset three cycles into WAIT restores priority to requester 0
    unit_lat = 2;
    req_valid = 4'b0010;
    waitFor(1, "mid_pre_rsp_seen", cyc);
    unit_lat = 0;
    req_valid = 4'b0100;
    waitFor(0, "mid_ack_seen", cyc);
    applyStimulus(3);
    rst_n = 1'b0; req_valid = '0; pend_cnt = 0;
    applyStimulus(1);
    checkOutput("mid_busy", 64'(busy), 64'd0);
    checkOutput("mid_rsp_data", rsp_data, 64'd0);
    checkOutput("mid_unit_a", unit_a, 64'd0);
    rst_n = 1'b1;
    applyStimulus(2);
    unit_auto = 1'b0;
    unit_finish = 1'b1; unit_result = 64'h5555;
    applyStimulus(1);
    unit_auto = 1'b1;
    checkOutput("mid_late_finish", 64'(rsp_valid), 64'd0);
    unit_lat = 2;
    req_valid = 4'hF;
    waitFor(0, "mid_first_ack_seen", cyc);
    checkOutput("mid_first_ack", 64'(req_ack), 64'h1);

    // Random traffic with random readiness, latency, hangs and stray finishes
    spurious_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i*W +: W] = $realtobits(real'($urandom_range(0, 1000)) / 8.0);
          req_b[i*W +: W] = $realtobits(real'($urandom_range(1, 64)) / 4.0);
        end else if (req_valid[i] && $urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_a[i*W +: W] = $realtobits(real'($urandom_range(0, 1000)) / 8.0);
        end
      end
      unit_ready = ($urandom_range(0, 3) != 0);
      unit_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      applyStimulus(1);
    end
    spurious_en = 1'b0; req_valid = '0; unit_ready = 1'b1;
    applyStimulus(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_unit_share_arbiter.md
Name: fp_unit_share_arbiter

Overview:
- Round-robin arbiter that time-shares one fp_adder or fp_multiplier instance (valid/ready/finish handshake) between N_REQ requesters, e.g. the CEU channel sequencers.
- Exactly one operation is in flight at a time.
- Grants a requester, latches its operands, issues them to the shared unit, and routes the result back to the granted requester with a one-cycle response pulse.
- A watchdog aborts a hung operation and raises a sticky error.

Parameters:
- DBL_WIDTH, 64, operand/result width (IEEE-754 double).
- N_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(N_REQ), owner index width.
- TIMEOUT_CYC, 255, maximum WAIT cycles before abort (1..65535).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous active-low.
- req_valid  in  N_REQ  per-requester request level; held until the matching req_ack.
- req_a  in  N_REQ*DBL_WIDTH  packed operand a; slice i belongs to requester i.
- req_b  in  N_REQ*DBL_WIDTH  packed operand b.
- req_ack  out  N_REQ  one-cycle pulse: operation issued to the unit.
- rsp_valid  out  N_REQ  one-cycle pulse: rsp_data is valid for requester i.
- rsp_data  out  DBL_WIDTH  shared result register.
- unit_valid  out  1  issue pulse to the shared fp unit.
- unit_ready  in  1  shared unit ready.
- unit_a  out  DBL_WIDTH  latched operand a to the unit.
- unit_b  out  DBL_WIDTH  latched operand b to the unit.
- unit_finish  in  1  unit result-valid pulse.
- unit_result  in  DBL_WIDTH  unit result.
- busy  out  1  high whenever the state is not IDLE.
- owner_id  out  IDX_W  index of the current or last granted requester.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: req_ack, rsp_valid, unit_valid, rsp_data, unit_a, unit_b, busy, owner_id, timeout_err.
  - last_grant resets to N_REQ-1; the watchdog timer resets to 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from (last_grant+1) mod N_REQ, with wrap-around.
  - On selection: owner_id <= selected index; unit_a/unit_b <= that requester's slices; go to ISSUE.
  - Operand changes after this edge are ignored.
- ISSUE:
  - While unit_ready=0, stay in ISSUE with no outputs changing.
  - When unit_ready=1 is sampled: next cycle unit_valid=1 and req_ack[owner_id]=1 (both single-cycle); timer <= 0; go to WAIT.
- WAIT:
  - unit_finish=1 sampled: rsp_data <= unit_result; rsp_valid[owner_id]=1 next cycle; last_grant <= owner_id; go to IDLE.
  - Otherwise timer increments. When timer reaches TIMEOUT_CYC-1 without finish: timeout_err <= 1, no rsp_valid, last_grant <= owner_id, go to IDLE.
  - If finish and timeout occur on the same edge, finish wins and no error is raised.
- unit_finish outside WAIT is ignored.
- Latency, from req_valid sampled in IDLE (edge 0) with unit_ready=1:
  - unit_valid/req_ack high after edge 1.
  - rsp_valid high one cycle after the edge that samples unit_finish.
- Re-arbitration:
  - A new grant can be made on the edge after rsp_valid is set, i.e. IDLE dwells 1 cycle.
  - A requester may re-assert req_valid immediately after req_ack; it is not re-granted before its rsp_valid, because only one operation is outstanding.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,…,N_REQ-1,0,…
- Requesters that drop req_valid before they are granted are simply not selected; there are no stale grants.
- timeout_err clears only on reset.
- Reset mid-operation:
  - Abandons the operation with no rsp_valid.
  - A unit_finish arriving after reset is ignored.

Test Plan:
- Single request: req_valid[2]=1, a=0x4008000000000000 (3.0), b=0x4000000000000000 (2.0); model multiplier, latency 6 -> req_ack=4'b0100 one cycle, rsp_valid=4'b0100 one cycle, rsp_data=0x4018000000000000 (6.0), owner_id=2.
- All four requesters held high, operands i and 1.0 -> req_ack order 0,1,2,3,0 and each rsp_data equals that requester's a; never two bits set in req_ack or rsp_valid.
- Backpressure: unit_ready=0 for 10 cycles after grant -> state holds ISSUE, no unit_valid or req_ack; both pulse exactly once, the cycle after unit_ready rises; unit_a is unchanged even though req_a is altered during the stall.
- Timeout: TIMEOUT_CYC=16, unit never finishes -> timeout_err=1 after 16 WAIT cycles, no rsp_valid; next pending requester is granted; a late unit_finish is ignored.
- Same-edge finish and timeout (finish on the cycle timer=TIMEOUT_CYC-1) -> rsp_valid pulses and timeout_err stays 0.
- Reset asserted 3 cycles into WAIT, then released -> all outputs 0, a unit_finish 2 cycles later produces no rsp_valid, and requester 0 has first priority again.
